ext_issue_ctrl: RTL and testbench
=================================

Name: ext_issue_ctrl

Overview:
Sequential successor to the single-cycle instruction decoder, covering the custom extension opcodes 5'b00010 (rd/rs1/rs2 form) and 5'b01010 (rd/rs1/imm form). It dispatches each extension op to one of NUM_EXT extension units through a valid/ready/done handshake and stalls the PC until the unit completes. It also enforces a completion timeout. It sits between fetch/decode and the extension units (AES encrypt/decrypt etc.); non-extension opcodes pass through with zero added latency.

Parameters:
NUM_EXT, 8, number of extension units; unit id = funct3, legal range 1..NUM_EXT-1 (id 0 is legal only in imm form), max 8
TIMEOUT_W, 16, width of the completion-timeout counter
TIMEOUT_CYCLES, 16'hFFFF, WAIT cycles before timeout abort; must be nonzero and fit TIMEOUT_W

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
inst_valid  in  1  decoded instruction present this cycle
opcode  in  5  inst[6:2]
funct3  in  3  inst[14:12]
ext_ready  in  NUM_EXT  per-unit request accept
ext_done  in  NUM_EXT  per-unit completion pulse
pc_we  out  1  PC advance strobe
reg_we  out  1  scalar register write (XD2R result, funct3==3 only)
ext_valid  out  NUM_EXT  one-hot request, held until ready
ext_imm  out  1  latched request is imm form (opcode 01010)
busy  out  1  FSM not in IDLE
illegal_ext  out  1  one-cycle pulse: unsupported unit id
err_timeout  out  1  sticky; cleared only by reset

Behaviour:
- Reset values: all outputs 0; state IDLE; timeout counter 0; latched id 0.
- Extension op = inst_valid & (opcode==5'b00010 | opcode==5'b01010).
- Unit id is illegal if funct3 >= NUM_EXT, or if funct3==0 and opcode==5'b00010.
- IDLE, non-extension instruction: pc_we = inst_valid combinationally; reg_we = 0.
- IDLE, illegal extension op: illegal_ext pulses, pc_we = 1, op executes as NOP, state stays IDLE.
- IDLE, legal extension op: pc_we = 0; latch id and form; next cycle enter ISSUE.
- ISSUE: ext_valid[id] = 1 from the registered state, stable until ext_ready[id]. The handshake is accepted on the cycle valid & ready are both high; next state is WAIT and the counter clears.
- ISSUE with ext_ready[id] & ext_done[id] in the same cycle: go directly to DONE.
- WAIT: counter increments each cycle (saturating); ext_done[id] -> DONE.
- WAIT, counter == TIMEOUT_CYCLES-1 with no done: go to DONE and set err_timeout. If done and timeout coincide, done wins and err_timeout stays clear.
- DONE (one cycle): pc_we = 1; reg_we = 1 iff form is reg and id==3 and no timeout; then IDLE.
- Done/ready bits for units other than the latched id are ignored at all times. ext_done outside WAIT/ISSUE is ignored.
- inst_valid is ignored while busy; fetch must hold the instruction, since PC does not advance.
- Latency: legal extension op = 1 (IDLE) + ISSUE cycles + WAIT cycles + 1 (DONE); minimum 3 cycles of pc_we low-then-high.
- Reset mid-operation: ext_valid drops on the first clk edge with rst_n low; no pc_we is issued.

Optional Feature:
EXT_PERF_CNT_EN
- Defined: adds 32-bit outputs stall_cycles (counts every cycle busy==1) and ext_ops (counts DONE entries). Both wrap at 2^32 and reset to 0.
- Undefined: neither port exists and no counter logic is synthesized.

Decomposition:
- Package ext_ctrl_pkg holds:
  - opcode constants OP_EXT_R=5'b00010, OP_EXT_I=5'b01010
  - the state enum {IDLE, ISSUE, WAIT, DONE} (2 bits)
  - the EXT_ID_XD2R=3'd3 constant
- One natural sub-module: ext_timeout_cnt (clear, enable, terminal-count flag).

Test Plan:
- Reset: rst_n low 2 cycles during ISSUE -> ext_valid, busy, pc_we all 0 at the first edge; state IDLE.
- opcode=5'b00100 with inst_valid=1 -> pc_we=1 the same cycle, busy=0, ext_valid=0.
- opcode=5'b00010, funct3=3, unit 3 ready after 2 cycles, done after 5 -> ext_valid=8'b00001000 for exactly 3 cycles, then DONE with pc_we=1 and reg_we=1.
- opcode=5'b01010, funct3=1, ready & done same cycle -> ISSUE->DONE directly, pc_we=1, reg_we=0, ext_imm=1.
- opcode=5'b00010, funct3=0 -> illegal_ext=1 for 1 cycle, pc_we=1, busy=0; same result for funct3=5 with NUM_EXT=4.
- TIMEOUT_CYCLES=4, unit never signals done -> DONE 4 cycles after WAIT entry, err_timeout=1 and sticky, reg_we=0; done arriving on the terminal cycle -> err_timeout=0.

Source files
------------

// File: rtl/ext_ctrl_pkg.sv
// Shared constants, state encoding and opcode helper for the extension-op issue controller.
package ext_ctrl_pkg;

    localparam logic [4:0] OP_EXT_R    = 5'b00010;
    localparam logic [4:0] OP_EXT_I    = 5'b01010;
    localparam logic [2:0] EXT_ID_XD2R = 3'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } ext_state_e;

    function automatic logic is_ext_op(input logic [4:0] op);
        return (op == OP_EXT_R) || (op == OP_EXT_I);
    endfunction

endpackage

// File: rtl/ext_timeout_cnt.sv
// Saturating completion-timeout counter with synchronous clear and terminal-count flag.
module ext_timeout_cnt #(
    parameter int             W    = 16,
    parameter logic [W-1:0]   TERM = {W{1'b1}}
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] LAST = TERM - ONE;

    logic [W-1:0] cnt_r;

    // Count while enabled, hold at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= {W{1'b0}};
        end else if (clr) begin
            cnt_r <= {W{1'b0}};
        end else if (en && (cnt_r != {W{1'b1}})) begin
            cnt_r <= cnt_r + ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tc = (cnt_r == LAST);

endmodule

// File: rtl/ext_issue_ctrl.sv
// Dispatches custom extension opcodes to extension units and stalls the PC until completion.
// Optional build macro EXT_PERF_CNT_EN adds stall_cycles / ext_ops performance counters.
module ext_issue_ctrl
    import ext_ctrl_pkg::*;
#(
    parameter int                   NUM_EXT        = 8,
    parameter int                   TIMEOUT_W      = 16,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 16'hFFFF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inst_valid,
    input  logic [4:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic [NUM_EXT-1:0] ext_ready,
    input  logic [NUM_EXT-1:0] ext_done,
    output logic               pc_we,
    output logic               reg_we,
    output logic [NUM_EXT-1:0] ext_valid,
    output logic               ext_imm,
    output logic               busy,
    output logic               illegal_ext,
    output logic               err_timeout
`ifdef EXT_PERF_CNT_EN
    ,
    output logic [31:0]        stall_cycles,
    output logic [31:0]        ext_ops
`endif
);

    ext_state_e         state_r;
    logic [2:0]         id_r;
    logic               imm_r;
    logic               busy_r;
    logic               done_r;
    logic               reg_we_r;
    logic               err_r;
    logic [NUM_EXT-1:0] ext_valid_r;

    logic [NUM_EXT-1:0] sel_s;
    logic [NUM_EXT-1:0] launch_oh_s;
    logic               idle_s;
    logic               ext_op_s;
    logic               illegal_s;
    logic               launch_s;
    logic               ready_s;
    logic               done_s;
    logic               xd2r_s;
    logic               tc_s;

    // One-hot decode of the latched unit id and of the incoming unit id.
    always_comb begin
        sel_s       = {NUM_EXT{1'b0}};
        launch_oh_s = {NUM_EXT{1'b0}};
        for (int i = 0; i < NUM_EXT; i++) begin
            sel_s[i]       = (id_r == 3'(i));
            launch_oh_s[i] = (funct3 == 3'(i));
        end
    end

    assign idle_s    = (state_r == IDLE);
    assign ext_op_s  = inst_valid & is_ext_op(opcode);
    assign illegal_s = (int'(funct3) >= NUM_EXT) | ((funct3 == 3'd0) & (opcode == OP_EXT_R));
    assign launch_s  = idle_s & ext_op_s & ~illegal_s;
    // Only the latched unit's handshake bits are observed.
    assign ready_s   = |(ext_ready & sel_s);
    assign done_s    = |(ext_done & sel_s);
    assign xd2r_s    = ~imm_r & (id_r == EXT_ID_XD2R);

    ext_timeout_cnt #(
        .W    (TIMEOUT_W),
        .TERM (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_r == ISSUE),
        .en    (state_r == WAIT),
        .tc    (tc_s)
    );

    // Issue FSM with registered handshake and completion outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            id_r        <= 3'd0;
            imm_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            reg_we_r    <= 1'b0;
            err_r       <= 1'b0;
            ext_valid_r <= {NUM_EXT{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    done_r   <= 1'b0;
                    reg_we_r <= 1'b0;
                    if (launch_s) begin
                        state_r     <= ISSUE;
                        id_r        <= funct3;
                        imm_r       <= (opcode == OP_EXT_I);
                        busy_r      <= 1'b1;
                        ext_valid_r <= launch_oh_s;
                    end
                end
                ISSUE: begin
                    if (ready_s) begin
                        ext_valid_r <= {NUM_EXT{1'b0}};
                        if (done_s) begin
                            state_r  <= DONE;
                            done_r   <= 1'b1;
                            reg_we_r <= xd2r_s;
                        end else begin
                            state_r <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // A done on the terminal cycle takes priority over the timeout.
                    if (done_s) begin
                        state_r  <= DONE;
                        done_r   <= 1'b1;
                        reg_we_r <= xd2r_s;
                    end else if (tc_s) begin
                        state_r  <= DONE;
                        done_r   <= 1'b1;
                        reg_we_r <= 1'b0;
                        err_r    <= 1'b1;
                    end
                end
                DONE: begin
                    state_r  <= IDLE;
                    busy_r   <= 1'b0;
                    done_r   <= 1'b0;
                    reg_we_r <= 1'b0;
                end
                default: begin
                    state_r     <= IDLE;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                    reg_we_r    <= 1'b0;
                    ext_valid_r <= {NUM_EXT{1'b0}};
                end
            endcase
        end
    end

    // Non-extension and illegal ops advance the PC in the same cycle; gated during reset.
    assign pc_we       = done_r | (rst_n & idle_s & inst_valid & ~launch_s);
    assign illegal_ext = rst_n & idle_s & ext_op_s & illegal_s;
    assign reg_we      = reg_we_r;
    assign ext_valid   = ext_valid_r;
    assign ext_imm     = imm_r;
    assign busy        = busy_r;
    assign err_timeout = err_r;

`ifdef EXT_PERF_CNT_EN
    logic [31:0] stall_r;
    logic [31:0] ops_r;

    // Free-running wrap-around performance counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_r <= 32'd0;
            ops_r   <= 32'd0;
        end else begin
            stall_r <= busy_r ? stall_r + 32'd1 : stall_r;
            ops_r   <= done_r ? ops_r + 32'd1 : ops_r;
        end
    end

    assign stall_cycles = stall_r;
    assign ext_ops      = ops_r;
`endif

endmodule

// File: tb/tb_ext_issue_ctrl.sv
// Directed plus randomized bench for ext_issue_ctrl against a per-transaction timing model.
module tb_ext_issue_ctrl;

    localparam int NE = 8;
    localparam int T  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       inst_valid = 1'b0;
    logic       inst_valid4 = 1'b0;
    logic [4:0] opcode = 5'd0;
    logic [2:0] funct3 = 3'd0;
    logic [7:0] ext_ready = 8'd0;
    logic [7:0] ext_done = 8'd0;
    logic [3:0] tie4 = 4'd0;

    logic       pc_we, reg_we, ext_imm, busy, illegal_ext, err_timeout;
    logic [7:0] ext_valid;
    logic       pc_we4, reg_we4, ext_imm4, busy4, illegal4, err4;
    logic [3:0] ext_valid4;
`ifdef EXT_PERF_CNT_EN
    logic [31:0] stall_cycles, ext_ops, stall_cycles4, ext_ops4;
`endif

    ext_issue_ctrl #(.NUM_EXT(NE), .TIMEOUT_W(16), .TIMEOUT_CYCLES(16'd4)) dut (
        .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .opcode(opcode), .funct3(funct3),
        .ext_ready(ext_ready), .ext_done(ext_done), .pc_we(pc_we), .reg_we(reg_we),
        .ext_valid(ext_valid), .ext_imm(ext_imm), .busy(busy), .illegal_ext(illegal_ext),
        .err_timeout(err_timeout)
`ifdef EXT_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .ext_ops(ext_ops)
`endif
    );

    ext_issue_ctrl #(.NUM_EXT(4), .TIMEOUT_W(16), .TIMEOUT_CYCLES(16'd4)) dut4 (
        .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid4), .opcode(opcode), .funct3(funct3),
        .ext_ready(tie4), .ext_done(tie4), .pc_we(pc_we4), .reg_we(reg_we4),
        .ext_valid(ext_valid4), .ext_imm(ext_imm4), .busy(busy4), .illegal_ext(illegal4),
        .err_timeout(err4)
`ifdef EXT_PERF_CNT_EN
        , .stall_cycles(stall_cycles4), .ext_ops(ext_ops4)
`endif
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   fails = 0;
    logic err_m = 1'b0;
    logic imm_m = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] unit_bit(input logic [2:0] f);
        logic [7:0] v;
        v = 8'd1;
        return v << f;
    endfunction

    function automatic bit is_ext(input logic [4:0] op);
        return (op == 5'b00010) || (op == 5'b01010);
    endfunction

    function automatic bit is_illegal(input logic [4:0] op, input logic [2:0] f, input int ne);
        return (int'(f) >= ne) || ((f == 3'd0) && (op == 5'b00010));
    endfunction

    // Legal extension op: unit ready r cycles after ISSUE entry; done at WAIT index w,
    // or together with ready when coin is set. Done later than index T-1 means timeout.
    task automatic run_op(input logic [4:0] op, input logic [2:0] f, input int r,
                          input bit coin, input int w);
        logic [7:0] m;
        int         dc;
        bit         to, xd, imm;
        m   = unit_bit(f);
        imm = (op == 5'b01010);
        xd  = !imm && (f == 3'd3);
        to  = !coin && (w > T - 1);
        dc  = coin ? 2 + r : (to ? 2 + r + T : 3 + r + w);
        inst_valid = 1'b1; opcode = op; funct3 = f;
        ext_ready = 8'($urandom) & ~m;
        ext_done  = 8'($urandom) & ~m;
        @(negedge clk);
        chk("idle_pc_we", pc_we, 32'd0);
        chk("idle_busy", busy, 32'd0);
        chk("idle_valid", ext_valid, 32'd0);
        chk("idle_illegal", illegal_ext, 32'd0);
        chk("idle_imm", ext_imm, imm_m);
        chk("idle_err", err_timeout, err_m);
        @(posedge clk); #1;
        imm_m = imm;
        for (int c = 1; c <= dc; c++) begin
            inst_valid = 1'($urandom); opcode = 5'($urandom); funct3 = 3'($urandom);
            ext_ready = (8'($urandom) & ~m) | ((c == 1 + r) ? m : 8'd0);
            ext_done  = (8'($urandom) & ~m) |
                        ((coin ? (c == 1 + r) : (c == 2 + r + w)) ? m : 8'd0);
            if (to && c == dc) err_m = 1'b1;
            @(negedge clk);
            chk("op_valid", ext_valid, (c <= 1 + r) ? m : 8'd0);
            chk("op_busy", busy, 32'd1);
            chk("op_pc_we", pc_we, (c == dc) ? 32'd1 : 32'd0);
            chk("op_reg_we", reg_we, (c == dc && xd && !to) ? 32'd1 : 32'd0);
            chk("op_imm", ext_imm, imm);
            chk("op_illegal", illegal_ext, 32'd0);
            chk("op_err", err_timeout, err_m);
            @(posedge clk); #1;
        end
        inst_valid = 1'b0; ext_ready = 8'd0; ext_done = 8'd0;
    endtask

    // Single IDLE cycle that must not start an operation.
    task automatic run_nop(input logic v, input logic [4:0] op, input logic [2:0] f);
        inst_valid = v; opcode = op; funct3 = f;
        ext_ready = 8'($urandom); ext_done = 8'($urandom);
        @(negedge clk);
        chk("nop_pc_we", pc_we, v);
        chk("nop_illegal", illegal_ext, (v && is_ext(op) && is_illegal(op, f, NE)) ? 32'd1 : 32'd0);
        chk("nop_busy", busy, 32'd0);
        chk("nop_valid", ext_valid, 32'd0);
        chk("nop_reg_we", reg_we, 32'd0);
        @(posedge clk); #1;
        inst_valid = 1'b0; ext_ready = 8'd0; ext_done = 8'd0;
        @(negedge clk);
        chk("nop_after_busy", busy, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [4:0] nonext [5];
        nonext[0] = 5'b00000; nonext[1] = 5'b00100; nonext[2] = 5'b01000;
        nonext[3] = 5'b11000; nonext[4] = 5'b11011;

        // Reset with a non-extension instruction present: pc_we must stay low.
        rst_n = 1'b0; inst_valid = 1'b1; opcode = 5'b00100;
        @(posedge clk); @(posedge clk); #1;
        @(negedge clk);
        chk("rst_pc_we", pc_we, 32'd0);
        chk("rst_reg_we", reg_we, 32'd0);
        chk("rst_valid", ext_valid, 32'd0);
        chk("rst_imm", ext_imm, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_illegal", illegal_ext, 32'd0);
        chk("rst_err", err_timeout, 32'd0);
        inst_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Unit id 5 is illegal for a 4-unit controller.
        inst_valid4 = 1'b1; opcode = 5'b00010; funct3 = 3'd5;
        @(negedge clk);
        chk("n4_illegal", illegal4, 32'd1);
        chk("n4_pc_we", pc_we4, 32'd1);
        chk("n4_busy", busy4, 32'd0);
        @(posedge clk); #1;
        inst_valid4 = 1'b0;
        @(negedge clk);
        chk("n4_pulse_end", illegal4, 32'd0);
        chk("n4_stay_idle", busy4, 32'd0);
        @(posedge clk); #1;

        run_nop(1'b1, 5'b00100, 3'd3);
        run_nop(1'b1, 5'b00010, 3'd0);
        run_nop(1'b0, 5'b00010, 3'd3);
        run_op(5'b00010, 3'd3, 2, 1'b0, 1);
        run_op(5'b01010, 3'd1, 0, 1'b1, 0);
        run_op(5'b01010, 3'd0, 1, 1'b0, 0);
        run_op(5'b00010, 3'd3, 0, 1'b0, T - 1);
        run_op(5'b00010, 3'd3, 1, 1'b0, 100);
        run_op(5'b00010, 3'd6, 0, 1'b0, 100);
        run_op(5'b01010, 3'd2, 0, 1'b0, 0);

        // Reset in the middle of ISSUE.
        inst_valid = 1'b1; opcode = 5'b00010; funct3 = 3'd2;
        @(posedge clk); #1;
        opcode = 5'b00100;
        @(negedge clk);
        chk("mid_valid", ext_valid, unit_bit(3'd2));
        chk("mid_busy", busy, 32'd1);
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("mid_rst_valid", ext_valid, 32'd0);
            chk("mid_rst_busy", busy, 32'd0);
            chk("mid_rst_pc_we", pc_we, 32'd0);
            chk("mid_rst_err", err_timeout, 32'd0);
        end
        rst_n = 1'b1; inst_valid = 1'b0;
        err_m = 1'b0; imm_m = 1'b0;
        @(posedge clk); #1;

        for (int n = 0; n < 40; n++) begin
            int          k;
            logic [4:0]  op;
            logic [2:0]  f;
            k = $urandom_range(0, 4);
            if (k == 0) begin
                run_nop(1'b1, nonext[$urandom_range(0, 4)], 3'($urandom));
            end else if (k == 1) begin
                run_nop(1'b1, 5'b00010, 3'd0);
            end else if (k == 2) begin
                run_nop(1'b0, ($urandom_range(0, 1) == 0) ? 5'b00010 : 5'b01010, 3'($urandom));
            end else begin
                op = ($urandom_range(0, 1) == 0) ? 5'b00010 : 5'b01010;
                f  = (op == 5'b00010) ? 3'($urandom_range(1, 7)) : 3'($urandom_range(0, 7));
                run_op(op, f, $urandom_range(0, 3), $urandom_range(0, 3) == 0, $urandom_range(0, 5));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
